// File: rtl/dae_pe_stream_pkg.sv
// Shared types for the DAE stream PE: ALU opcode enum, default geometry and
// the packed config word layout {acc_len, acc_en, const_en, op, sel_b, sel_a}.
package dae_pe_stream_pkg;

  localparam int PE_N_BITS    = 32;
  localparam int PE_N_INPUTS  = 8;
  localparam int PE_FU_LAT    = 2;
  localparam int PE_ACC_CNT_W = 8;

  localparam int LOG_N_INPUTS_PE = $clog2(PE_N_INPUTS);

  typedef enum logic [3:0] {
    PE_OP_ADD    = 4'd0,
    PE_OP_SUB    = 4'd1,
    PE_OP_MUL    = 4'd2,
    PE_OP_AND    = 4'd3,
    PE_OP_OR     = 4'd4,
    PE_OP_XOR    = 4'd5,
    PE_OP_SLL    = 4'd6,
    PE_OP_SRL    = 4'd7,
    PE_OP_SRA    = 4'd8,
    PE_OP_MIN    = 4'd9,
    PE_OP_MAX    = 4'd10,
    PE_OP_PASS_A = 4'd11
  } pe_alu_op_e;

  function automatic int pe_cfg_width(input int n_inputs, input int acc_cnt_w);
    return 2 * $clog2(n_inputs) + 4 + 1 + 1 + acc_cnt_w;
  endfunction

  localparam int PE_CFG_W = pe_cfg_width(PE_N_INPUTS, PE_ACC_CNT_W);

  // Layout at the default geometry; the PE redeclares it for its own parameters.
  typedef struct packed {
    logic [PE_ACC_CNT_W-1:0]    acc_len;
    logic                       acc_en;
    logic                       const_en;
    pe_alu_op_e                 op;
    logic [LOG_N_INPUTS_PE-1:0] sel_b;
    logic [LOG_N_INPUTS_PE-1:0] sel_a;
  } pe_stream_cfg_t;

endpackage

// File: rtl/dae_pe_stream_alu.sv
// Combinational ALU of the stream PE (pe_alu): wrap-around arithmetic,
// logic, shifts by the low log2(N_BITS) bits of b, signed min/max.
module dae_pe_stream_alu
  import dae_pe_stream_pkg::*;
#(
  parameter int N_BITS = PE_N_BITS
) (
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  input  pe_alu_op_e        op_i,
  output logic [N_BITS-1:0] res_o
);

  localparam int SH_W = $clog2(N_BITS);

  logic [SH_W-1:0] sh;
  assign sh = b_i[SH_W-1:0];

  always_comb begin
    res_o = '0;
    case (op_i)
      PE_OP_ADD:    res_o = a_i + b_i;
      PE_OP_SUB:    res_o = a_i - b_i;
      PE_OP_MUL:    res_o = a_i * b_i;
      PE_OP_AND:    res_o = a_i & b_i;
      PE_OP_OR:     res_o = a_i | b_i;
      PE_OP_XOR:    res_o = a_i ^ b_i;
      PE_OP_SLL:    res_o = a_i << sh;
      PE_OP_SRL:    res_o = a_i >> sh;
      PE_OP_SRA:    res_o = $signed(a_i) >>> sh;
      PE_OP_MIN:    res_o = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
      PE_OP_MAX:    res_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
      PE_OP_PASS_A: res_o = a_i;
      default:      res_o = '0;
    endcase
  end

endmodule

// File: rtl/dae_pe_stream.sv
// DAE stream processing element: operand select, FU_LAT-deep stallable pipe,
// optional reduce-add accumulation and double-buffered configuration.
module dae_pe_stream
  import dae_pe_stream_pkg::*;
#(
  parameter  int N_BITS    = PE_N_BITS,
  parameter  int N_INPUTS  = PE_N_INPUTS,
  parameter  int FU_LAT    = PE_FU_LAT,
  parameter  int ACC_CNT_W = PE_ACC_CNT_W,
  localparam int SEL_W     = $clog2(N_INPUTS),
  localparam int CFG_W     = pe_cfg_width(N_INPUTS, ACC_CNT_W)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [N_INPUTS*N_BITS-1:0] pe_op_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [CFG_W-1:0]           cfg_i,
  input  logic [N_BITS-1:0]          cfg_const_i,
  input  logic                       cfg_we_i,
  output logic                       cfg_pending_o,
  output logic [N_BITS-1:0]          pe_res_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i
);

  typedef struct packed {
    logic [ACC_CNT_W-1:0] acc_len;
    logic                 acc_en;
    logic                 const_en;
    pe_alu_op_e           op;
    logic [SEL_W-1:0]     sel_b;
    logic [SEL_W-1:0]     sel_a;
  } cfg_t;

  cfg_t               shadow_q, shadow_d, active_q, active_d;
  logic [N_BITS-1:0]  sconst_q, sconst_d, const_q, const_d;
  logic               pending_q, pending_d;
  logic               init_q;
  logic               out_valid_q, out_valid_d;
  logic [N_BITS-1:0]  res_q, res_d;
  logic [N_BITS-1:0]  acc_q, acc_d;
  logic [ACC_CNT_W-1:0] cnt_q, cnt_d, eff_last;

  logic              advance, accept, apply, pipe_busy, tail_v;
  logic [N_BITS-1:0] op_a, op_b, alu_res, tail_d;
  logic [N_BITS-1:0] ops [N_INPUTS];

  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_ops
      assign ops[gi] = pe_op_i[gi*N_BITS +: N_BITS];
    end
  endgenerate

  assign advance    = !out_valid_q || out_ready_i;
  assign in_ready_o = advance && !pending_q && init_q;
  assign accept     = in_valid_i && in_ready_o;

  assign op_a = ops[active_q.sel_a];
  assign op_b = active_q.const_en ? const_q : ops[active_q.sel_b];

  dae_pe_stream_alu #(.N_BITS(N_BITS)) u_alu (
    .a_i   (op_a),
    .b_i   (op_b),
    .op_i  (active_q.op),
    .res_o (alu_res)
  );

  // Stage 0 is the ALU output in the accept cycle; busy ORs only registered stages.
  generate
    for (gi = 0; gi < FU_LAT; gi++) begin : g_stg
      logic              stg_v;
      logic [N_BITS-1:0] stg_d;
      logic              busy;
      if (gi == 0) begin : g_head
        assign stg_v = accept;
        assign stg_d = alu_res;
        assign busy  = 1'b0;
      end else begin : g_reg
        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            stg_v <= 1'b0;
            stg_d <= '0;
          end else if (advance) begin
            stg_v <= g_stg[gi-1].stg_v;
            stg_d <= g_stg[gi-1].stg_d;
          end
        end
        assign busy = stg_v || g_stg[gi-1].busy;
      end
    end
  endgenerate

  assign tail_v    = g_stg[FU_LAT-1].stg_v;
  assign tail_d    = g_stg[FU_LAT-1].stg_d;
  assign pipe_busy = g_stg[FU_LAT-1].busy;

  assign eff_last = (active_q.acc_len == '0) ? '0 : active_q.acc_len - 1'b1;

  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (advance) begin
      out_valid_d = 1'b0;
      if (tail_v) begin
        if (active_q.acc_en) begin
          if (cnt_q >= eff_last) begin
            out_valid_d = 1'b1;
            res_d       = acc_q + tail_d;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            acc_d = acc_q + tail_d;
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          out_valid_d = 1'b1;
          res_d       = tail_d;
        end
      end
    end
  end

  // A write in the apply cycle lands in the shadow and keeps pending set.
  always_comb begin
    apply     = pending_q && !pipe_busy && (cnt_q == '0) && !out_valid_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    sconst_d  = sconst_q;
    active_d  = active_q;
    const_d   = const_q;
    if (apply) begin
      active_d  = shadow_q;
      const_d   = sconst_q;
      pending_d = 1'b0;
    end
    if (cfg_we_i) begin
      shadow_d  = cfg_t'(cfg_i);
      sconst_d  = cfg_const_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shadow_q    <= '0;
      active_q    <= '0;
      sconst_q    <= '0;
      const_q     <= '0;
      pending_q   <= 1'b0;
      init_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      sconst_q    <= sconst_d;
      const_q     <= const_d;
      pending_q   <= pending_d;
      init_q      <= 1'b1;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign pe_res_o      = res_q;
  assign cfg_pending_o = pending_q;

endmodule

// File: tb/tb_dae_pe_stream.sv
// Scoreboard bench for dae_pe_stream: directed vectors push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_dae_pe_stream;
  import dae_pe_stream_pkg::*;

  localparam int NB  = PE_N_BITS;
  localparam int NI  = PE_N_INPUTS;
  localparam int CW  = PE_CFG_W;
  localparam int PER = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NI*NB-1:0] pe_op = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CW-1:0]    cfg = '0;
  logic [NB-1:0]    cfg_const = '0;
  logic             cfg_we = 1'b0;
  logic             cfg_pending;
  logic [NB-1:0]    pe_res;
  logic             out_valid;
  logic             out_ready = 1'b1;

  int tests = 0;
  int fails = 0;
  logic [NB-1:0] exp_q [$];
  logic          hold_chk = 1'b0;
  logic [NB-1:0] hold_val = '0;

  dae_pe_stream dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .pe_op_i       (pe_op),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .cfg_i         (cfg),
    .cfg_const_i   (cfg_const),
    .cfg_we_i      (cfg_we),
    .cfg_pending_o (cfg_pending),
    .pe_res_o      (pe_res),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready)
  );

  always #(PER/2) clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [NB-1:0] got, input logic [NB-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end else begin
      $display("[TB] check %s = %h ok", name, got);
    end
  endtask

  // Monitor: output handshakes pop the scoreboard; stalled outputs must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_chk) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", pe_res, hold_val);
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_output: got %h, expected none", pe_res);
        end else begin
          logic [NB-1:0] e;
          e = exp_q.pop_front();
          if (pe_res !== e) begin
            fails++;
            $display("[TB] FAIL result: got %h, expected %h", pe_res, e);
          end else begin
            $display("[TB] out %h ok", pe_res);
          end
        end
      end
      hold_chk = out_valid && !out_ready;
      hold_val = pe_res;
    end else begin
      hold_chk = 1'b0;
    end
  end

  function automatic logic [CW-1:0] mk(input pe_alu_op_e op, input int sa, input int sb,
                                        input bit ce, input bit ae, input int len);
    pe_stream_cfg_t c;
    c.sel_a    = LOG_N_INPUTS_PE'(sa);
    c.sel_b    = LOG_N_INPUTS_PE'(sb);
    c.op       = op;
    c.const_en = ce;
    c.acc_en   = ae;
    c.acc_len  = PE_ACC_CNT_W'(len);
    return c;
  endfunction

  task automatic cfg_write(input logic [CW-1:0] w, input logic [NB-1:0] k);
    cfg       = w;
    cfg_const = k;
    cfg_we    = 1'b1;
    @(posedge clk); #1;
    cfg_we    = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input int ia, input logic [NB-1:0] a, input int ib, input logic [NB-1:0] b);
    int waited;
    waited = 0;
    pe_op = '0;
    pe_op[ia*NB +: NB] = a;
    pe_op[ib*NB +: NB] = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      if (waited > 300) begin
        tests++;
        fails++;
        $display("[TB] FAIL send_timeout: in_ready stuck at 0, required 1");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    time t0;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_res", pe_res, 32'd0);
    check("rst_pending", {31'd0, cfg_pending}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // ADD sel_a=1 sel_b=2, latency and throughput
    cfg_write(mk(PE_OP_ADD, 1, 2, 0, 0, 0), '0);
    exp_q.push_back(32'd12);
    send(1, 32'd5, 2, 32'd7);
    @(negedge clk);
    check("lat_stage1_not_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_fu_lat_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd30);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'd0);
    t0 = $time;
    send(1, 32'd1, 2, 32'd2);
    send(1, 32'd10, 2, 32'd20);
    send(1, 32'hFFFF_FFFE, 2, 32'd1);
    send(1, 32'hFFFF_FFFF, 2, 32'd1);
    check("b2b_elapsed", 32'($time - t0), 32'(4 * PER));
    drain();

    // Backpressure: 3 tokens with out_ready low for 5 cycles
    out_ready = 1'b0;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    fork
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join_none
    send(1, 32'd1, 2, 32'd0);
    send(1, 32'd2, 2, 32'd0);
    send(1, 32'd3, 2, 32'd0);
    drain();

    // MUL with accumulation
    cfg_write(mk(PE_OP_MUL, 1, 2, 0, 1, 4), '0);
    exp_q.push_back(32'd100);
    for (int i = 0; i < 4; i++) send(1, 32'(2*i+1), 2, 32'(2*i+2));
    exp_q.push_back(32'd30);
    for (int i = 1; i <= 4; i++) send(1, 32'(i), 2, 32'(i));
    drain();
    cfg_write(mk(PE_OP_MUL, 1, 2, 0, 1, 0), '0);
    exp_q.push_back(32'd15);
    exp_q.push_back(32'd4);
    send(1, 32'd3, 2, 32'd5);
    send(1, 32'd2, 2, 32'd2);
    drain();

    // Config commit with two tokens in flight
    cfg_write(mk(PE_OP_ADD, 1, 2, 0, 0, 0), '0);
    exp_q.push_back(32'd12);
    exp_q.push_back(32'd13);
    exp_q.push_back(32'hFFFF_FFFE);
    send(1, 32'd5, 2, 32'd7);
    cfg       = mk(PE_OP_SUB, 1, 2, 0, 0, 0);
    cfg_const = '0;
    cfg_we    = 1'b1;
    send(1, 32'd10, 2, 32'd3);
    cfg_we    = 1'b0;
    @(negedge clk);
    check("commit_pending", {31'd0, cfg_pending}, 32'd1);
    check("commit_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    send(1, 32'd5, 2, 32'd7);
    drain();

    // Constant operand and special ops
    cfg_write(mk(PE_OP_SUB, 3, 4, 1, 0, 0), 32'hFFFF_FFFF);
    exp_q.push_back(32'd1);
    send(3, 32'd0, 4, 32'd9);
    drain();
    cfg_write(mk(PE_OP_SRA, 1, 2, 0, 0, 0), '0);
    exp_q.push_back(32'hF800_0000);
    send(1, 32'h8000_0000, 2, 32'd4);
    drain();
    cfg_write(mk(PE_OP_MIN, 1, 2, 0, 0, 0), '0);
    exp_q.push_back(32'hFFFF_FFFF);
    send(1, 32'hFFFF_FFFF, 2, 32'd1);
    drain();
    cfg_write(mk(PE_OP_MAX, 1, 2, 0, 0, 0), '0);
    exp_q.push_back(32'd1);
    send(1, 32'hFFFF_FFFF, 2, 32'd1);
    drain();
    cfg_write(mk(pe_alu_op_e'(4'hF), 1, 2, 0, 0, 0), '0);
    exp_q.push_back(32'd0);
    send(1, 32'd123, 2, 32'd456);
    drain();

    // Reset mid-accumulation, then a fresh sum
    cfg_write(mk(PE_OP_MUL, 1, 2, 0, 1, 4), '0);
    send(1, 32'd1, 2, 32'd2);
    send(1, 32'd3, 2, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_pending", {31'd0, cfg_pending}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cfg_write(mk(PE_OP_MUL, 1, 2, 0, 1, 4), '0);
    exp_q.push_back(32'd4);
    for (int i = 0; i < 4; i++) send(1, 32'd1, 2, 32'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
